alu_vec_pipe: RTL and testbench

Parametrised, registered successor to the 16-bit combinational ALU. It operates on `LANES` independent `WIDTH`-bit lanes and uses a valid/ready handshake on both the input and output sides. It adds XOR, shift-left, unsigned saturating add and an optional iterative multiply. It sits between operand fetch and writeback in the vector datapath and provides a registered result plus per-lane flags.

---
 rtl/alu_vec_pipe.sv | 177 +++++++++++++++++
 tb/tb_alu_vec_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_pipe.sv
// Registered multi-lane ALU with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module alu_vec_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   A,
  input  logic [LANES*WIDTH-1:0]   B,
  input  logic [2:0]               ALUControl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   Res,
  output logic [5*LANES-1:0]       Flags
);
  localparam int SH = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_ADDS = 3'b110;

  logic                   accept;
  logic                   single_op;
  logic [LANES*WIDTH-1:0] alu_res;
  logic [5*LANES-1:0]     alu_flags;

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam logic [2:0]    OP_MUL   = 3'b111;
  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    MUL      = 1'b1;
  localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);

  logic [0:0]               state_reg;
  logic [SH-1:0]            count_reg;
  logic [LANES*2*WIDTH-1:0] acc_reg, acc_next;
  logic [LANES*2*WIDTH-1:0] mcand_reg, mcand_next, mcand_load;
  logic [LANES*WIDTH-1:0]   mplier_reg, mplier_next;
  logic [LANES*WIDTH-1:0]   mul_res;
  logic [5*LANES-1:0]       mul_flags;
  logic                     start_mul;
  logic                     mul_done;

  assign start_mul = accept && (ALUControl == OP_MUL);
  assign single_op = accept && (ALUControl != OP_MUL);
  assign mul_done  = (state_reg == MUL) && (count_reg == CNT_LAST);
  assign in_ready  = (state_reg == IDLE) && (!out_valid || out_ready);
`else
  assign single_op = accept;
  assign in_ready  = !out_valid || out_ready;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] a, b, res;
      logic [WIDTH:0]   sum, diff, shl;
      logic             c, v, sat;

      assign a    = A[gi*WIDTH +: WIDTH];
      assign b    = B[gi*WIDTH +: WIDTH];
      assign sum  = {1'b0, a} + {1'b0, b};
      assign diff = {1'b0, a} - {1'b0, b};
      // The extra top bit catches the last bit shifted out; it stays 0 for a zero shift.
      assign shl  = {1'b0, a} << b[SH-1:0];

      always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        sat = 1'b0;
        case (ALUControl)
          OP_ADD: begin
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SUB: begin
            res = diff[WIDTH-1:0];
            c   = !diff[WIDTH];
            v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
          end
          OP_AND: res = a & b;
          OP_OR:  res = a | b;
          OP_XOR: res = a ^ b;
          OP_SHL: begin
            res = shl[WIDTH-1:0];
            c   = shl[WIDTH];
          end
          OP_ADDS: begin
            res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            c   = sum[WIDTH];
            sat = sum[WIDTH];
          end
          default: res = '0;
        endcase
      end

      assign alu_res[gi*WIDTH +: WIDTH] = res;
      assign alu_flags[gi*5 +: 5]       = {res[WIDTH-1], (res == '0), c, v, sat};

`ifdef ALU_MUL_EN
      logic [2*WIDTH-1:0] mcand, acc_step;
      logic [WIDTH-1:0]   mplier;
      logic               hi_nz;

      assign mcand    = mcand_reg[gi*2*WIDTH +: 2*WIDTH];
      assign mplier   = mplier_reg[gi*WIDTH +: WIDTH];
      assign acc_step = acc_reg[gi*2*WIDTH +: 2*WIDTH] + (mplier[0] ? mcand : '0);
      assign hi_nz    = (acc_step[2*WIDTH-1:WIDTH] != '0);

      assign acc_next[gi*2*WIDTH +: 2*WIDTH]   = acc_step;
      assign mcand_next[gi*2*WIDTH +: 2*WIDTH] = mcand << 1;
      assign mcand_load[gi*2*WIDTH +: 2*WIDTH] = {{WIDTH{1'b0}}, a};
      assign mplier_next[gi*WIDTH +: WIDTH]    = mplier >> 1;
      assign mul_res[gi*WIDTH +: WIDTH]        = acc_step[WIDTH-1:0];
      assign mul_flags[gi*5 +: 5] =
        {acc_step[WIDTH-1], (acc_step[WIDTH-1:0] == '0), hi_nz, hi_nz, 1'b0};
`endif
    end
  endgenerate

`ifdef ALU_MUL_EN
  // Final iteration's sum is written straight to Res, so latency is exactly WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (start_mul) begin
      state_reg  <= MUL;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= mcand_load;
      mplier_reg <= B;
    end else if (state_reg == MUL) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      count_reg  <= count_reg + 1'b1;
      if (mul_done) begin
        state_reg <= IDLE;
        count_reg <= '0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Res       <= '0;
      Flags     <= '0;
    end else if (single_op) begin
      out_valid <= 1'b1;
      Res       <= alu_res;
      Flags     <= alu_flags;
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      out_valid <= 1'b1;
      Res       <= mul_res;
      Flags     <= mul_flags;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_vec_pipe.sv
// Directed self-checking bench for alu_vec_pipe (WIDTH=16, LANES=2).
// Opcode 111 checks follow whether ALU_MUL_EN is defined.
module tb_alu_vec_pipe;
  localparam int WIDTH = 16;
  localparam int LANES = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] A = '0;
  logic [LANES*WIDTH-1:0] B = '0;
  logic [2:0]             ALUControl = 3'b000;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [LANES*WIDTH-1:0] Res;
  logic [5*LANES-1:0]     Flags;

  int assertions = 0;
  int failures   = 0;

  alu_vec_pipe #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Res(Res), .Flags(Flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl = op;
    A          = a;
    B          = b;
    in_valid   = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    assertions++;
    if (out_valid !== 1'b0 || Res !== '0 || Flags !== '0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b Res=%h Flags=%b, required 0/0/0", out_valid, Res, Flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith;
    logic [2:0]  ops [6] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001};
    logic [15:0] av  [6] = '{16'hFFFF, 16'h0007, 16'h0007, 16'h0000, 16'h7FFF, 16'h8000};
    logic [15:0] bv  [6] = '{16'h0001, 16'h0007, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
    logic [15:0] rv  [6] = '{16'h0000, 16'h000E, 16'h0007, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [4:0]  fv  [6] = '{5'b01100, 5'b00000, 5'b00100, 5'b10000, 5'b10010, 5'b00110};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], {16'h0000, av[i]}, {16'h0000, bv[i]});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      assertions++;
      if (out_valid !== 1'b1 || Res[15:0] !== rv[i]) begin
        failures++;
        $display("FAIL arith_res[%0d]: out_valid=%b Res=%h, required 1/%h", i, out_valid, Res[15:0], rv[i]);
      end
      assertions++;
      if (Flags[4:0] !== fv[i]) begin
        failures++;
        $display("FAIL arith_flags[%0d]: got %b, required %b", i, Flags[4:0], fv[i]);
      end
    end
  endtask

  task automatic test_logic_shift;
    logic [2:0]  ops [6] = '{3'b100, 3'b010, 3'b011, 3'b101, 3'b101, 3'b101};
    logic [15:0] av  [6] = '{16'hF0F0, 16'hF0F0, 16'h00F0, 16'h8001, 16'h1234, 16'h0003};
    logic [15:0] bv  [6] = '{16'hFF00, 16'hFF00, 16'h0F00, 16'h0001, 16'h0010, 16'h000F};
    logic [15:0] rv  [6] = '{16'h0FF0, 16'hF000, 16'h0FF0, 16'h0002, 16'h1234, 16'h8000};
    logic [4:0]  fv  [6] = '{5'b00000, 5'b10000, 5'b00000, 5'b00100, 5'b00000, 5'b10100};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], {16'h0000, av[i]}, {16'h0000, bv[i]});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      assertions++;
      if (Res[15:0] !== rv[i] || Flags[4:0] !== fv[i]) begin
        failures++;
        $display("FAIL logic_shift[%0d]: Res=%h Flags=%b, required %h/%b", i, Res[15:0], Flags[4:0], rv[i], fv[i]);
      end
    end
  endtask

  task automatic test_adds;
    drive(3'b110, {16'h0001, 16'hFFF0}, {16'h0002, 16'h0020});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    assertions++;
    if (Res !== 32'h0003_FFFF) begin
      failures++;
      $display("FAIL adds_res: got %h, required 0003ffff", Res);
    end
    assertions++;
    if (Flags !== 10'b00000_10101) begin
      failures++;
      $display("FAIL adds_flags: got %b, required 0000010101", Flags);
    end
  endtask

  task automatic test_op111;
`ifdef ALU_MUL_EN
    logic [31:0] av [2] = '{32'h0003_0100, 32'h00FF_FFFF};
    logic [31:0] bv [2] = '{32'h0005_0100, 32'h0101_FFFF};
    logic [31:0] rv [2] = '{32'h000F_0000, 32'hFFFF_0001};
    logic [9:0]  fv [2] = '{10'b00000_01110, 10'b10000_00110};
    int cyc;
    logic ready_seen;
    for (int i = 0; i < 2; i++) begin
      drive(3'b111, av[i], bv[i]);
      assertions++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL mul_accept[%0d]: in_ready=%b, required 1", i, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      cyc        = 0;
      ready_seen = 1'b0;
      while (out_valid !== 1'b1 && cyc < 40) begin
        if (in_ready !== 1'b0) ready_seen = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
      end
      assertions++;
      if (cyc != WIDTH) begin
        failures++;
        $display("FAIL mul_latency[%0d]: got %0d cycles, required %0d", i, cyc, WIDTH);
      end
      assertions++;
      if (ready_seen) begin
        failures++;
        $display("FAIL mul_in_ready_low[%0d]: in_ready rose during MUL, required 0", i);
      end
      assertions++;
      if (Res !== rv[i] || Flags !== fv[i]) begin
        failures++;
        $display("FAIL mul_result[%0d]: Res=%h Flags=%b, required %h/%b", i, Res, Flags, rv[i], fv[i]);
      end
    end
`else
    drive(3'b111, 32'h1234_FFFF, 32'h5678_0001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    assertions++;
    if (out_valid !== 1'b1 || Res !== '0 || Flags !== 10'b01000_01000) begin
      failures++;
      $display("FAIL op111: out_valid=%b Res=%h Flags=%b, required 1/00000000/0100001000", out_valid, Res, Flags);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops [3] = '{3'b000, 3'b001, 3'b100};
    logic [15:0] av  [3] = '{16'h0010, 16'h0010, 16'h000F};
    logic [15:0] bv  [3] = '{16'h0001, 16'h0001, 16'h00FF};
    logic [15:0] rv  [3] = '{16'h0011, 16'h000F, 16'h00F0};
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    assertions++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: out_valid=%b, required 0", out_valid);
    end
    out_ready = 1'b0;
    drive(3'b000, 32'h0000_0001, 32'h0000_0002);
    @(posedge clk);
    #1;
    assertions++;
    if (out_valid !== 1'b1 || Res[15:0] !== 16'h0003) begin
      failures++;
      $display("FAIL bp_first: out_valid=%b Res=%h, required 1/0003", out_valid, Res[15:0]);
    end
    drive(3'b000, 32'h0000_0004, 32'h0000_0005);
    for (int i = 0; i < 2; i++) begin
      assertions++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, in_ready);
      end
      @(posedge clk);
      #1;
      assertions++;
      if (out_valid !== 1'b1 || Res[15:0] !== 16'h0003 || Flags[4:0] !== 5'b00000) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b Res=%h Flags=%b, required 1/0003/00000", i, out_valid, Res[15:0], Flags[4:0]);
      end
    end
    out_ready = 1'b1;
    #1;
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    assertions++;
    if (out_valid !== 1'b1 || Res[15:0] !== 16'h0009) begin
      failures++;
      $display("FAIL bp_second: out_valid=%b Res=%h, required 1/0009", out_valid, Res[15:0]);
    end
    @(posedge clk);
    #1;
    assertions++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_clear: out_valid=%b, required 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], {16'h0000, av[i]}, {16'h0000, bv[i]});
      @(posedge clk);
      #1;
      assertions++;
      if (out_valid !== 1'b1 || Res[15:0] !== rv[i]) begin
        failures++;
        $display("FAIL stream[%0d]: out_valid=%b Res=%h, required 1/%h", i, out_valid, Res[15:0], rv[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    logic stale;
`ifdef ALU_MUL_EN
    drive(3'b111, 32'h0003_0003, 32'h0005_0005);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
`else
    out_ready = 1'b0;
    drive(3'b000, 32'h0000_1234, 32'h0000_0001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    assertions++;
    if (out_valid !== 1'b0 || Res !== '0 || Flags !== '0) begin
      failures++;
      $display("FAIL reset_mid: out_valid=%b Res=%h Flags=%b, required 0/0/0", out_valid, Res, Flags);
    end
    out_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    #1;
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready: got %b, required 1", in_ready);
    end
    stale = 1'b0;
    repeat (24) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    assertions++;
    if (stale) begin
      failures++;
      $display("FAIL reset_no_stale: out_valid rose after reset, required 0");
    end
    drive(3'b000, 32'h0000_0002, 32'h0000_0003);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    assertions++;
    if (out_valid !== 1'b1 || Res[15:0] !== 16'h0005) begin
      failures++;
      $display("FAIL post_reset_op: out_valid=%b Res=%h, required 1/0005", out_valid, Res[15:0]);
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic_shift;
    test_adds;
    test_op111;
    test_back_to_back;
    test_reset_mid_op;
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
